seg_src_arb: RTL and testbench
==============================

SEG_SRC_ARB -- requirements
Module: seg_src_arb

Interface
REQ-001 SHALL have parameter DWELL_MAX, default 25'd24_999_999; minimum owner dwell in cycles minus 1 (0.5 s at 50 MHz).
REQ-002 SHALL have parameter BLANK_MAX, default 16'd49_999; blank gap between owners in cycles minus 1 (1 ms).
REQ-003 sys_clk  in  1  single clock; all logic on rising edge.
REQ-004 sys_rst  in  1  synchronous, active-high reset.
REQ-005 req0 / req1  in  1  display request from source 0 / 1.
REQ-006 data0 / data1  in  20  unsigned value of source 0 / 1.
REQ-007 point0 / point1  in  6  decimal-point mask of source 0 / 1.
REQ-008 sign0 / sign1  in  1  negative flag of source 0 / 1.
REQ-009 prio1  in  1  source 1 may preempt source 0 (alarm).
REQ-010 gnt0 / gnt1  out  1  source 0 / 1 owns the display.
REQ-011 data  out  20  displayed value, clamped.
REQ-012 point  out  6  displayed point mask.
REQ-013 sign  out  1  displayed sign.
REQ-014 seg_en  out  1  display enable for the downstream seg/595 driver.
REQ-015 owner  out  1  index of the last granted source.
REQ-016 upd  out  1  one-cycle pulse: displayed bundle changed.

Function
REQ-017 SHALL implement the states IDLE, OWN0, OWN1 and BLANK.
REQ-018 IDLE: seg_en=0 and gnt=00; if any req, go to OWNx on the next edge per the arbitration rule.
REQ-019 Arbitration rule: a single requester wins.
- Both requesting with prio1=1: source 1 wins.
- Both requesting otherwise: the source not last served wins (rr pointer; after reset source 0 wins).
REQ-020 OWNx: gntx=1 and seg_en=1.
- data/point/sign are registered from source x every cycle (1-cycle latency).
- dwell counter increments from 0 and saturates at DWELL_MAX.
REQ-021 OWNx exits to BLANK on any of:
- reqx low;
- dwell==DWELL_MAX with the other req high;
- in OWN0, req1&&prio1 (immediate preemption, dwell ignored).
REQ-022 OWNx stays in OWNx at dwell==DWELL_MAX while the other req is low.
REQ-023 BLANK: seg_en=0, gnt=00, data/point/sign held; counts 0..BLANK_MAX, then re-arbitrates per REQ-019 to OWNx, or to IDLE if no req.
REQ-024 Entering OWNx updates owner and the rr pointer, and clears the dwell counter.
REQ-025 Clamp: if selected data > 20'd999_999 (6 digits), data output SHALL be 20'd999_999; sign and point pass unchanged.
REQ-026 upd SHALL pulse:
- on the first OWN cycle after IDLE/BLANK;
- on any OWN cycle where the registered data/point/sign differ from the previous cycle.
REQ-027 upd SHALL never pulse while seg_en=0.
REQ-028 Simultaneous events: req drop and preemption in the same cycle give one BLANK; a source dropping req during BLANK is not granted.
REQ-029 prio1 has no effect while in OWN1 or IDLE except via REQ-019.

Reset
REQ-030 While sys_rst=1 at an edge, the block SHALL go to:
- state IDLE; gnt0=gnt1=0, seg_en=0, upd=0;
- data=0, point=0, sign=0, owner=0;
- rr pointer = 0; dwell and blank counters = 0.
REQ-031 Reset mid-OWN or mid-BLANK SHALL abort immediately; the first grant after release follows REQ-019 from the reset pointer.

Structure
REQ-032 Shared package seg_pkg SHALL hold:
- the state encoding;
- DISP_MAX=20'd999_999;
- data/point widths 20/6, shared with data_gen.
REQ-033 One sub-module, arb_timer, SHALL provide a loadable saturating counter with a terminal flag, used for both dwell and blank; everything else stays inline.

Verification (DWELL_MAX=9, BLANK_MAX=2)
REQ-034 Reset held 3 cycles with req0=1 -> all outputs 0; one cycle after release gnt0=1, then seg_en=1 and upd=1 one cycle later.
REQ-035 req0 and req1 held with prio1=0, data0=123, data1=456:
- data=123 for 10 cycles;
- then 3 cycles of seg_en=0;
- then data=456 and gnt1=1; alternation continues.
REQ-036 OWN0 at dwell 3, assert req1 and prio1 -> next cycle BLANK (gnt0=0, seg_en=0), then 3 cycles later gnt1=1, owner=1.
REQ-037 data0=20'hFFFFF -> data=999999; data0=999999 -> 999999; data0=0 with sign0=1 -> data=0, sign=1.
REQ-038 In OWN0, data0 changes 5->6 -> exactly one upd pulse, one cycle after the change; unchanged data -> no upd.
REQ-039 req0 alone past dwell 9 -> stays OWN0, no BLANK; drop req0 -> BLANK, then IDLE with seg_en=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the segment display source arbiter.
// Holds FSM encoding, display bundle layout and the 6-digit clamp.
package seg_pkg;

  localparam int DATA_W = 20;
  localparam int PNT_W  = 6;

  localparam logic [DATA_W-1:0] DISP_MAX = 20'd999_999;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN0  = 2'd1,
    S_OWN1  = 2'd2,
    S_BLANK = 2'd3
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [PNT_W-1:0]  point;
    logic [DATA_W-1:0] data;
  } disp_t;

  function automatic logic [DATA_W-1:0] clamp(
    input logic [DATA_W-1:0] d
  );
    return (d > DISP_MAX) ? DISP_MAX : d;
  endfunction

endpackage

// File: rtl/seg_src_arb_if.sv
// Bundle between two display sources and the arbiter.
// master: source side (drives req/data), slave: arbiter side.
interface seg_src_arb_if;
  import seg_pkg::*;

  logic              req0;
  logic              req1;
  logic [DATA_W-1:0] data0;
  logic [DATA_W-1:0] data1;
  logic [PNT_W-1:0]  point0;
  logic [PNT_W-1:0]  point1;
  logic              sign0;
  logic              sign1;
  logic              prio1;

  logic              gnt0;
  logic              gnt1;
  logic [DATA_W-1:0] data;
  logic [PNT_W-1:0]  point;
  logic              sign;
  logic              seg_en;
  logic              owner;
  logic              upd;

  modport master (
    output req0, req1, data0, data1,
    output point0, point1, sign0, sign1,
    output prio1,
    input  gnt0, gnt1, data, point,
    input  sign, seg_en, owner, upd
  );

  modport slave (
    input  req0, req1, data0, data1,
    input  point0, point1, sign0, sign1,
    input  prio1,
    output gnt0, gnt1, data, point,
    output sign, seg_en, owner, upd
  );

endinterface

// File: rtl/arb_timer.sv
// Loadable saturating up-counter with terminal flag.
// Ports: clk, rst (sync), ld/ld_val load, en count, term at MAX.
module arb_timer #(
  parameter int         W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic         term
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (en && cnt != MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == MAX);

endmodule

// File: rtl/seg_src_arb.sv
// Two-source arbiter for a 6-digit segment display with dwell/blank.
// Ports: sys_clk, sys_rst (sync, high), bus (slave side of the bundle).
module seg_src_arb
  import seg_pkg::*;
#(
  parameter logic [24:0] DWELL_MAX = 25'd24_999_999,
  parameter logic [15:0] BLANK_MAX = 16'd49_999
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  seg_src_arb_if.slave  bus
);

  state_t state;
  state_t next_state;
  state_t arb_state;

  logic  dwell_end;
  logic  blank_end;
  logic  any_req;
  logic  win;
  logic  own_now;
  logic  own_next;
  logic  enter;
  logic  seg_en_d;
  logic  diff;

  logic  rr_q;
  logic  owner_q;
  logic  seg_en_q;
  logic  upd_q;
  disp_t disp_q;
  disp_t sel;

  // rr_q holds the index preferred on a tie
  always_comb begin
    any_req = bus.req0 | bus.req1;
    win     = rr_q;
    unique case (1'b1)
      (bus.req0 && !bus.req1): win = 1'b0;
      (bus.req1 && !bus.req0): win = 1'b1;
      (bus.req1 && bus.prio1): win = 1'b1;
      default:                 win = rr_q;
    endcase
    arb_state = win ? S_OWN1 : S_OWN0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (any_req) next_state = arb_state;
      end
      S_OWN0: begin
        if (!bus.req0 ||
            (dwell_end && bus.req1) ||
            (bus.req1 && bus.prio1))
          next_state = S_BLANK;
      end
      S_OWN1: begin
        if (!bus.req1 || (dwell_end && bus.req0))
          next_state = S_BLANK;
      end
      S_BLANK: begin
        if (blank_end)
          next_state = any_req ? arb_state : S_IDLE;
      end
    endcase
  end

  assign own_now  = (state == S_OWN0) || (state == S_OWN1);
  assign own_next = (next_state == S_OWN0) ||
                    (next_state == S_OWN1);
  assign enter    = own_next && !own_now;
  // display is enabled only for cycles that stay in the same owner
  assign seg_en_d = own_now && (next_state == state);

  arb_timer #(
    .W   (25),
    .MAX (DWELL_MAX)
  ) u_dwell (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .ld     (!own_now),
    .ld_val (25'd0),
    .en     (own_now),
    .term   (dwell_end)
  );

  arb_timer #(
    .W   (16),
    .MAX (BLANK_MAX)
  ) u_blank (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .ld     (state != S_BLANK),
    .ld_val (16'd0),
    .en     (state == S_BLANK),
    .term   (blank_end)
  );

  always_comb begin
    if (state == S_OWN1) begin
      sel.sign  = bus.sign1;
      sel.point = bus.point1;
      sel.data  = clamp(bus.data1);
    end else begin
      sel.sign  = bus.sign0;
      sel.point = bus.point0;
      sel.data  = clamp(bus.data0);
    end
    diff = (sel != disp_q);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      disp_q   <= '0;
      seg_en_q <= 1'b0;
      upd_q    <= 1'b0;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
    end else begin
      seg_en_q <= seg_en_d;
      // seg_en_q low here marks the first owned cycle
      upd_q    <= seg_en_d && (!seg_en_q || diff);
      if (own_now) disp_q <= sel;
      if (enter) begin
        owner_q <= (next_state == S_OWN1);
        rr_q    <= (next_state != S_OWN1);
      end
    end
  end

  always_comb begin
    bus.gnt0   = (state == S_OWN0);
    bus.gnt1   = (state == S_OWN1);
    bus.seg_en = seg_en_q;
    bus.upd    = upd_q;
    bus.data   = disp_q.data;
    bus.point  = disp_q.point;
    bus.sign   = disp_q.sign;
    bus.owner  = owner_q;
  end

endmodule

// File: tb/tb_seg_src_arb.sv
// Directed self-checking bench for seg_src_arb.
// DWELL_MAX=9, BLANK_MAX=2; inputs driven and outputs checked #1 after edge.
module tb_seg_src_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  seg_src_arb_if bus ();

  seg_src_arb #(
    .DWELL_MAX (25'd9),
    .BLANK_MAX (16'd2)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic ctl(
    input string tag,
    input logic  g0,
    input logic  g1,
    input logic  en,
    input logic  up
  );
    chk({tag, ".gnt0"}, {31'd0, bus.gnt0}, {31'd0, g0});
    chk({tag, ".gnt1"}, {31'd0, bus.gnt1}, {31'd0, g1});
    chk({tag, ".seg_en"}, {31'd0, bus.seg_en}, {31'd0, en});
    chk({tag, ".upd"}, {31'd0, bus.upd}, {31'd0, up});
  endtask

  task automatic dat(
    input string       tag,
    input logic [19:0] d,
    input logic        s
  );
    chk({tag, ".data"}, {12'd0, bus.data}, {12'd0, d});
    chk({tag, ".sign"}, {31'd0, bus.sign}, {31'd0, s});
  endtask

  initial begin
    bus.req0   = 1'b1;
    bus.req1   = 1'b0;
    bus.data0  = 20'd5;
    bus.data1  = 20'd0;
    bus.point0 = 6'h03;
    bus.point1 = 6'h00;
    bus.sign0  = 1'b0;
    bus.sign1  = 1'b0;
    bus.prio1  = 1'b0;

    // reset held 3 cycles with req0 high
    step(); step(); step();
    ctl("rst", 0, 0, 0, 0);
    dat("rst", 20'd0, 0);
    chk("rst.point", {26'd0, bus.point}, 32'd0);
    chk("rst.owner", {31'd0, bus.owner}, 32'd0);
    rst = 1'b0;

    step();
    ctl("first_gnt", 1, 0, 0, 0);
    step();
    ctl("first_en", 1, 0, 1, 1);
    dat("first_en", 20'd5, 0);
    chk("first.point", {26'd0, bus.point}, 32'd3);
    chk("first.owner", {31'd0, bus.owner}, 32'd0);
    step();
    ctl("steady", 1, 0, 1, 0);

    // data change 5 -> 6 gives one upd pulse
    bus.data0 = 20'd6;
    step();
    ctl("chg", 1, 0, 1, 1);
    dat("chg", 20'd6, 0);
    step();
    ctl("chg_after", 1, 0, 1, 0);

    // req0 alone past dwell limit stays owned
    for (int i = 0; i < 12; i++) step();
    ctl("dwell_sat", 1, 0, 1, 0);

    bus.req0 = 1'b0;
    step();
    ctl("drop_blank", 0, 0, 0, 0);
    dat("drop_blank", 20'd6, 0);
    step(); step(); step();
    ctl("drop_idle", 0, 0, 0, 0);
    step();
    ctl("idle_hold", 0, 0, 0, 0);

    // clamp
    bus.data0 = 20'hFFFFF;
    bus.req0  = 1'b1;
    step();
    ctl("clamp_gnt", 1, 0, 0, 0);
    step();
    ctl("clamp_big", 1, 0, 1, 1);
    dat("clamp_big", 20'd999_999, 0);
    bus.data0 = 20'd999_999;
    step();
    ctl("clamp_eq", 1, 0, 1, 0);
    dat("clamp_eq", 20'd999_999, 0);
    bus.data0 = 20'd0;
    bus.sign0 = 1'b1;
    step();
    ctl("zero_neg", 1, 0, 1, 1);
    dat("zero_neg", 20'd0, 1);

    // reset mid-own aborts
    rst = 1'b1;
    step();
    ctl("mid_rst", 0, 0, 0, 0);
    dat("mid_rst", 20'd0, 0);

    // both requesting, round-robin alternation
    rst        = 1'b0;
    bus.req0   = 1'b1;
    bus.req1   = 1'b1;
    bus.data0  = 20'd123;
    bus.data1  = 20'd456;
    bus.sign0  = 1'b0;
    bus.point0 = 6'h00;
    step();
    ctl("rr_own0", 1, 0, 0, 0);
    chk("rr_own0.owner", {31'd0, bus.owner}, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      step();
      ctl("rr_dwell0", 1, 0, 1, (i == 1));
      dat("rr_dwell0", 20'd123, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      ctl("rr_blank", 0, 0, 0, 0);
      dat("rr_blank", 20'd123, 0);
    end
    step();
    ctl("rr_own1", 0, 1, 0, 0);
    chk("rr_own1.owner", {31'd0, bus.owner}, 32'd1);
    step();
    ctl("rr_own1_en", 0, 1, 1, 1);
    dat("rr_own1_en", 20'd456, 0);
    for (int i = 0; i < 8; i++) step();
    ctl("rr_own1_end", 0, 1, 1, 0);
    step();
    ctl("rr_blank2", 0, 0, 0, 0);
    step(); step();
    step();
    ctl("rr_back0", 1, 0, 0, 0);
    chk("rr_back0.owner", {31'd0, bus.owner}, 32'd0);

    // preemption at dwell 3
    step(); step(); step();
    ctl("pre_dwell3", 1, 0, 1, 0);
    bus.prio1 = 1'b1;
    step();
    ctl("pre_blank", 0, 0, 0, 0);
    step(); step();
    ctl("pre_blank2", 0, 0, 0, 0);
    step();
    ctl("pre_own1", 0, 1, 0, 0);
    chk("pre_own1.owner", {31'd0, bus.owner}, 32'd1);

    // drop during blank is not granted
    bus.req1  = 1'b0;
    bus.prio1 = 1'b0;
    step();
    ctl("d1_blank", 0, 0, 0, 0);
    bus.req0 = 1'b0;
    step(); step(); step();
    ctl("d1_idle", 0, 0, 0, 0);
    step();
    ctl("d1_idle2", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
